// File: rtl/life_grid_ctrl_if.sv
// life_grid_ctrl_if: bundles the control/data signals between the grid
// controller and its environment (stimulus + evolve datapath).
//   load/start/stop/step : single-cycle command pulses
//   init_state           : pattern captured on load
//   grid_evolve          : next generation from the combinational evolve path
//   grid/generation      : current grid register and committed generation count
//   running/stable       : state flags (RUN / HALT)
interface life_grid_ctrl_if;
  logic         load;
  logic [255:0] init_state;
  logic         start;
  logic         stop;
  logic         step;
  logic [255:0] grid_evolve;
  logic [255:0] grid;
  logic [15:0]  generation;
  logic         running;
  logic         stable;

  modport master (
    output load, init_state, start, stop, step, grid_evolve,
    input  grid, generation, running, stable
  );

  modport slave (
    input  load, init_state, start, stop, step, grid_evolve,
    output grid, generation, running, stable
  );
endinterface

// File: rtl/life_grid_ctrl.sv
// life_grid_ctrl: clocked grid-state stage in front of the Game-of-Life evolve
// datapath. Holds the 16x16 grid, loads a pattern, commits grid_evolve on a
// step (IDLE) or every TICKS cycles (RUN), counts generations (saturating) and
// parks in HALT when the pattern stops changing (STOP_ON_STABLE=1).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : life_grid_ctrl_if.slave (commands, init_state, grid_evolve in;
//           grid, generation, running, stable out -- all registered)
module life_grid_ctrl #(
  parameter int TICKS          = 4,
  parameter bit STOP_ON_STABLE = 1'b1
) (
  input logic             clk,
  input logic             reset,
  life_grid_ctrl_if.slave bus
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [255:0]   grid_q, grid_d;
  logic [15:0]    gen_q, gen_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic           running_q, running_d;
  logic           stable_q, stable_d;
  logic           upd;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      running_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      stable_q  <= stable_d;
    end
  end

  // Next-state: one action per edge, load > stop > start > step
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    gen_d   = gen_q;
    tick_d  = tick_q;
    upd     = 1'b0;

    if (bus.load) begin
      grid_d  = bus.init_state;
      gen_d   = '0;
      tick_d  = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // stop is a no-op here but still masks start/step on the same edge
          if (!bus.stop) begin
            if (bus.start) begin
              state_d = S_RUN;
              tick_d  = '0;
            end else if (bus.step) begin
              upd = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            // leaving RUN drops any update that was due this edge
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (tick_q == TMAX) begin
            tick_d = '0;
            upd    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_HALT: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (upd) begin
      if (bus.grid_evolve != grid_q) begin
        grid_d = bus.grid_evolve;
        gen_d  = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
      end else if (STOP_ON_STABLE) begin
        state_d = S_HALT;
      end
    end
  end

  // Outputs: flags derived from next state so they are registered alongside it
  always_comb begin
    running_d = (state_d == S_RUN);
    stable_d  = (state_d == S_HALT);
  end

  assign bus.grid       = grid_q;
  assign bus.generation = gen_q;
  assign bus.running    = running_q;
  assign bus.stable     = stable_q;

endmodule

// File: tb/tb_life_grid_ctrl.sv
module tb_life_grid_ctrl;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  life_grid_ctrl_if bif1 ();
  life_grid_ctrl_if bif2 ();

  // Reference Game-of-Life datapath (dead cells outside the 16x16 field)
  function automatic logic [255:0] life(input logic [255:0] g);
    logic [255:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr; cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
              cnt += int'(g[rr*16+cc]);
          end
        n[r*16+c] = (cnt == 3) || (g[r*16+c] && cnt == 2);
      end
    return n;
  endfunction

  assign bif1.grid_evolve = life(bif1.grid);
  assign bif2.grid_evolve = life(bif2.grid);

  life_grid_ctrl #(.TICKS(4), .STOP_ON_STABLE(1'b1)) dut1 (.clk(clk), .reset(rst1), .bus(bif1));
  life_grid_ctrl #(.TICKS(1), .STOP_ON_STABLE(1'b0)) dut2 (.clk(clk), .reset(rst2), .bus(bif2));

  typedef struct {
    logic         rst, ld, sta, sto, stp;
    logic [255:0] init;
    logic [255:0] e_grid;
    logic [15:0]  e_gen;
    logic         e_run, e_stb;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [255:0] bl_h, bl_v, blk, zero;

  task automatic add(input logic r, ld, sta, sto, stp, input logic [255:0] init,
                     input logic [255:0] eg, input logic [15:0] egen,
                     input logic er, es);
    vec_t v;
    v.rst = r; v.ld = ld; v.sta = sta; v.sto = sto; v.stp = stp; v.init = init;
    v.e_grid = eg; v.e_gen = egen; v.e_run = er; v.e_stb = es;
    vq.push_back(v);
  endtask

  // idle cycles with unchanged expectation
  task automatic nop(input int n, input logic [255:0] eg, input logic [15:0] egen,
                     input logic er, es);
    for (int i = 0; i < n; i++) add(0,0,0,0,0, zero, eg, egen, er, es);
  endtask

  task automatic chk_g(input string nm, input logic [255:0] a, e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s grid got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  initial begin
    zero = '0;
    bl_h = '0; bl_h[118] = 1'b1; bl_h[119] = 1'b1; bl_h[120] = 1'b1;
    bl_v = '0; bl_v[103] = 1'b1; bl_v[119] = 1'b1; bl_v[135] = 1'b1;
    blk  = '0; blk[119] = 1'b1; blk[120] = 1'b1; blk[135] = 1'b1; blk[136] = 1'b1;

    rst1 = 1'b1; rst2 = 1'b1;
    bif1.load = 0; bif1.start = 0; bif1.stop = 0; bif1.step = 0; bif1.init_state = '0;
    bif2.load = 0; bif2.start = 0; bif2.stop = 0; bif2.step = 0; bif2.init_state = '0;

    //  rst ld sta sto stp init   grid  gen run stb
    add(1, 1, 1, 1, 1, bl_h,  zero, 0, 0, 0);   // reset beats everything
    add(0, 1, 0, 0, 0, bl_h,  bl_h, 0, 0, 0);   // load blinker
    add(0, 0, 0, 0, 1, zero,  bl_v, 1, 0, 0);   // step
    add(0, 0, 0, 0, 1, zero,  bl_h, 2, 0, 0);   // step
    nop(1, bl_h, 2, 0, 0);
    // free run, TICKS=4, first update 4 edges after start
    add(0, 1, 0, 0, 0, bl_h,  bl_h, 0, 0, 0);
    add(0, 0, 1, 0, 0, zero,  bl_h, 0, 1, 0);   // E
    add(0, 0, 0, 0, 1, zero,  bl_h, 0, 1, 0);   // step ignored in RUN
    add(0, 0, 1, 0, 0, zero,  bl_h, 0, 1, 0);   // start ignored in RUN
    nop(1, bl_h, 0, 1, 0);
    add(0, 0, 0, 0, 0, zero,  bl_v, 1, 1, 0);   // E+4
    nop(3, bl_v, 1, 1, 0);
    add(0, 0, 0, 0, 0, zero,  bl_h, 2, 1, 0);   // E+8
    nop(3, bl_h, 2, 1, 0);
    add(0, 0, 0, 0, 0, zero,  bl_v, 3, 1, 0);   // E+12
    // load+start in RUN: load wins, start dropped
    add(0, 1, 1, 0, 0, bl_h,  bl_h, 0, 0, 0);
    nop(5, bl_h, 0, 0, 0);
    // stop on the update edge suppresses the update
    add(0, 0, 1, 0, 0, zero,  bl_h, 0, 1, 0);   // E
    nop(3, bl_h, 0, 1, 0);
    add(0, 0, 0, 0, 0, zero,  bl_v, 1, 1, 0);   // E+4
    nop(3, bl_v, 1, 1, 0);
    add(0, 0, 0, 1, 0, zero,  bl_v, 1, 0, 0);   // E+8 with stop
    nop(4, bl_v, 1, 0, 0);
    add(0, 0, 1, 1, 0, zero,  bl_v, 1, 0, 0);   // stop+start in IDLE
    add(0, 0, 0, 1, 1, zero,  bl_v, 1, 0, 0);   // stop masks step
    // still life
    add(0, 1, 0, 0, 0, blk,   blk,  0, 0, 0);
    add(0, 0, 1, 0, 0, zero,  blk,  0, 1, 0);   // E
    nop(3, blk, 0, 1, 0);
    add(0, 0, 0, 0, 0, zero,  blk,  0, 0, 1);   // E+4 -> HALT
    add(0, 0, 1, 0, 0, zero,  blk,  0, 0, 1);
    add(0, 0, 0, 0, 1, zero,  blk,  0, 0, 1);
    add(0, 0, 0, 1, 0, zero,  blk,  0, 0, 1);
    nop(2, blk, 0, 0, 1);
    add(0, 1, 0, 0, 0, bl_h,  bl_h, 0, 0, 0);   // load exits HALT
    // empty grid is stable
    add(0, 1, 0, 0, 0, zero,  zero, 0, 0, 0);
    add(0, 0, 0, 0, 1, zero,  zero, 0, 0, 1);
    // reset mid-RUN with counter at 2
    add(0, 1, 0, 0, 0, bl_h,  bl_h, 0, 0, 0);
    add(0, 0, 1, 0, 0, zero,  bl_h, 0, 1, 0);
    nop(2, bl_h, 0, 1, 0);
    add(1, 0, 0, 0, 0, zero,  zero, 0, 0, 0);
    add(0, 1, 0, 0, 0, bl_h,  bl_h, 0, 0, 0);
    add(0, 0, 1, 0, 0, zero,  bl_h, 0, 1, 0);   // new E
    nop(3, bl_h, 0, 1, 0);
    add(0, 0, 0, 0, 0, zero,  bl_v, 1, 1, 0);   // exactly 4 edges later

    foreach (vq[i]) begin
      @(negedge clk);
      rst1 = vq[i].rst; bif1.load = vq[i].ld; bif1.start = vq[i].sta;
      bif1.stop = vq[i].sto; bif1.step = vq[i].stp; bif1.init_state = vq[i].init;
      @(posedge clk); #1;
      chk_g($sformatf("v%0d", i), bif1.grid, vq[i].e_grid);
      chk($sformatf("v%0d gen", i), 32'(bif1.generation), 32'(vq[i].e_gen));
      chk($sformatf("v%0d running", i), 32'(bif1.running), 32'(vq[i].e_run));
      chk($sformatf("v%0d stable", i), 32'(bif1.stable), 32'(vq[i].e_stb));
    end

    // TICKS=1, STOP_ON_STABLE=0: empty grid keeps running
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b0; bif2.load = 1'b1; bif2.init_state = zero;
    @(negedge clk); bif2.load = 1'b0; bif2.start = 1'b1;
    @(negedge clk); bif2.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("nostop running", 32'(bif2.running), 32'd1);
    chk("nostop stable", 32'(bif2.stable), 32'd0);
    chk("nostop gen", 32'(bif2.generation), 32'd0);

    // blinker, update every edge, then saturation
    bif2.load = 1'b1; bif2.init_state = bl_h;
    @(negedge clk); bif2.load = 1'b0; bif2.start = 1'b1;
    @(negedge clk); bif2.start = 1'b0;          // start edge: no update
    chk_g("t1 start", bif2.grid, bl_h);
    @(negedge clk);
    chk_g("t1 upd1", bif2.grid, bl_v);
    chk("t1 gen1", 32'(bif2.generation), 32'd1);
    @(negedge clk);
    chk_g("t1 upd2", bif2.grid, bl_h);
    chk("t1 gen2", 32'(bif2.generation), 32'd2);
    force dut2.gen_q = 16'hFFFE;
    #1 release dut2.gen_q;
    @(negedge clk);
    chk("sat FFFF", 32'(bif2.generation), 32'hFFFF);
    chk_g("sat grid", bif2.grid, bl_v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sat hold", 32'(bif2.generation), 32'hFFFF);
      chk("sat running", 32'(bif2.running), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/life_grid_ctrl.md
Name: life_grid_ctrl

Overview:
- Sequential grid-state stage that sits in front of the combinational Game-of-Life evolve datapath (256-bit grid in, 256-bit grid_evolve out).
- Holds the current 16x16 grid in a register and drives it to the evolve datapath.
- Loads an initial pattern and commits grid_evolve back into the register on single-step or free-run ticks.
- Counts generations and detects still lifes; replaces hand-driven grid feedback with a clocked controller.

Parameters:
- TICKS, 4: clock cycles per generation in RUN (>=1).
- STOP_ON_STABLE, 1: 1 = enter HALT when grid_evolve equals grid at an update point; 0 = keep running.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  pulse; capture init_state into grid.
- init_state  input  256  initial pattern.
- start  input  1  pulse; enter free-run.
- stop  input  1  pulse; leave free-run.
- step  input  1  pulse; advance one generation when idle.
- grid_evolve  input  256  next-generation grid from the evolve datapath.
- grid  output  256  current grid register; row r = grid[16r+15:16r], column c = bit c of the row.
- generation  output  16  generations committed since last load or reset.
- running  output  1  1 while in RUN.
- stable  output  1  1 while in HALT.

Behaviour:
- Reset, synchronous and sampled each edge:
  - grid=0, generation=0, state=IDLE, tick counter=0.
  - running=0, stable=0.
  - Reset overrides all other inputs.
- Input priority, one action per edge: reset > load > stop > start > step.
- States are IDLE, RUN and HALT. All outputs are registered; running=(state==RUN) and stable=(state==HALT).
- Load, from any state:
  - grid<=init_state, generation<=0, tick counter<=0, state<=IDLE.
  - Grid takes the new value on the same edge; grid_evolve from the new grid is valid the next cycle.
- Update rule, used by step and by RUN ticks:
  - If grid_evolve!=grid: grid<=grid_evolve and generation<=generation+1. generation saturates at 16'hFFFF and never wraps.
  - If grid_evolve==grid: grid and generation are unchanged. If STOP_ON_STABLE=1, state<=HALT.
- IDLE:
  - step: one update on that edge. State stays IDLE unless the update rule sends it to HALT.
  - start: state<=RUN, tick counter<=0, no update on that edge.
  - stop: ignored.
- RUN:
  - Tick counter increments each cycle from 0 to TICKS-1.
  - When the counter equals TICKS-1, apply the update rule and set counter<=0.
  - First update occurs TICKS edges after the edge that accepted start.
  - stop: state<=IDLE and counter<=0. Any update due on that edge is suppressed.
  - start or step in RUN: ignored.
  - TICKS=1: an update on every edge while in RUN.
- HALT:
  - start, step and stop are ignored.
  - Only load or reset leave HALT.
  - grid holds the stable pattern.
- Empty grid: all-zero grid evolves to all-zero, so it is treated as stable (HALT when STOP_ON_STABLE=1).
- Simultaneous inputs:
  - load with start: load wins, start is dropped. start must be reasserted on a later cycle.
  - stop with start in IDLE: stop wins, which is a no-op.
- Reset mid-RUN: next edge gives the reset values above; the partial tick count is discarded.
- Combinational paths: none from inputs to outputs.

Test Plan:
- Reset/load: assert reset with any inputs, then load with init_state bits 118,119,120 set (row 7, cols 6-8 blinker) -> after reset grid=0, generation=0, running=0; after load grid has exactly bits 118-120 set, generation=0.
- Single step: blinker loaded, pulse step once, evolve datapath connected -> next edge grid has exactly bits 103,119,135; generation=1; state stays IDLE. Second step -> bits 118-120; generation=2.
- Free run, TICKS=4: blinker loaded, pulse start at edge E -> running=1 from E. grid changes only at E+4, E+8, E+12; generation=3 after E+12. stop at E+8 -> no update at E+8, generation=1, running=0.
- Still life, STOP_ON_STABLE=1: load 2x2 block (bits 119,120,135,136), start -> at E+TICKS stable=1, running=0, generation=0, grid unchanged. Subsequent start/step ignored; load exits HALT to IDLE with stable=0.
- Empty grid and saturation:
  - load all-zero, step -> HALT, generation=0.
  - With STOP_ON_STABLE=0, TICKS=1, blinker run, generation force-preloaded to 16'hFFFE -> reaches 16'hFFFF and stays there.
- Priority: same cycle load=1, start=1 in RUN -> IDLE, grid=init_state. Reset asserted mid-RUN (counter=2) -> all reset values next edge, and the first update after a new start occurs exactly TICKS edges later.
